// File: rtl/writeback_stage_if.sv
// MEM->WB retirement bus, data-memory load response and register-file write-back port.
// Pure wiring; no storage and no added latency.
// mem_ready from the stage is the only backpressure; dmem responses cannot be stalled.
interface writeback_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic [4:0]  mem_rn;
  logic [31:0] mem_alu;
  logic        mem_wz;
  logic        mem_z;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_wreg;
  logic [4:0]  wb_rn;
  logic [31:0] wdi;
  logic        wb_z;
  logic        load_err;
  logic [31:0] wb_retired;

  // MEM stage / memory / register-file side (drives requests, observes results)
  modport master (
    output mem_valid, mem_wreg, mem_m2reg, mem_rn, mem_alu, mem_wz, mem_z,
    output dmem_rvalid, dmem_rdata,
    input  mem_ready, wb_wreg, wb_rn, wdi, wb_z, load_err, wb_retired
  );

  // Write-back stage side
  modport slave (
    input  mem_valid, mem_wreg, mem_m2reg, mem_rn, mem_alu, mem_wz, mem_z,
    input  dmem_rvalid, dmem_rdata,
    output mem_ready, wb_wreg, wb_rn, wdi, wb_z, load_err, wb_retired
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back controller (register-file write, Z flag, retire count).
// ALU results commit 1 cycle after accept; loads commit on the edge where dmem_rvalid is seen.
// mem_ready drops for the whole load wait; a load with no response for LOAD_TIMEOUT cycles is aborted.
module writeback_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             clrn,
  writeback_stage_if.slave bus_io
);

  localparam int unsigned CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        hold_wreg_q, hold_wreg_d;
  logic [4:0]  hold_rn_q, hold_rn_d;
  logic        hold_wz_q, hold_wz_d;
  logic        hold_z_q, hold_z_d;
  logic        wreg_q, wreg_d;
  logic [4:0]  rn_q, rn_d;
  logic [31:0] wdi_q, wdi_d;
  logic        z_q, z_d;
  logic        err_q, err_d;
  logic [31:0] retired_q, retired_d;
  logic        accept;

  assign bus_io.mem_ready  = (state_q == IDLE);
  assign accept            = bus_io.mem_valid && (state_q == IDLE);
  assign bus_io.wb_wreg    = wreg_q;
  assign bus_io.wb_rn      = rn_q;
  assign bus_io.wdi        = wdi_q;
  assign bus_io.wb_z       = z_q;
  assign bus_io.load_err   = err_q;
  assign bus_io.wb_retired = retired_q;

  // Next-state and commit decisions; write enable is a single-cycle pulse by default
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_wreg_d = hold_wreg_q;
    hold_rn_d   = hold_rn_q;
    hold_wz_d   = hold_wz_q;
    hold_z_d    = hold_z_q;
    wreg_d      = 1'b0;
    rn_d        = rn_q;
    wdi_d       = wdi_q;
    z_d         = z_q;
    err_d       = err_q;
    retired_d   = retired_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_wreg_d = bus_io.mem_wreg;
          hold_rn_d   = bus_io.mem_rn;
          hold_wz_d   = bus_io.mem_wz;
          hold_z_d    = bus_io.mem_z;
          if (!bus_io.mem_m2reg) begin
            // r0 is hard-wired zero, so never raise the write strobe for it
            wreg_d    = bus_io.mem_wreg && (bus_io.mem_rn != 5'd0);
            rn_d      = bus_io.mem_rn;
            wdi_d     = bus_io.mem_alu;
            if (bus_io.mem_wz) z_d = bus_io.mem_z;
            retired_d = retired_q + 32'd1;
          end else begin
            // A response arriving alongside the load itself belongs to nothing; ignore it
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        if (bus_io.dmem_rvalid) begin
          // Response wins over a coincident timeout
          wreg_d    = hold_wreg_q && (hold_rn_q != 5'd0);
          rn_d      = hold_rn_q;
          wdi_d     = bus_io.dmem_rdata;
          if (hold_wz_q) z_d = hold_z_q;
          retired_d = retired_q + 32'd1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers; reset abandons any pending load
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_wreg_q <= 1'b0;
      hold_rn_q   <= 5'd0;
      hold_wz_q   <= 1'b0;
      hold_z_q    <= 1'b0;
      wreg_q      <= 1'b0;
      rn_q        <= 5'd0;
      wdi_q       <= 32'd0;
      z_q         <= 1'b0;
      err_q       <= 1'b0;
      retired_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_wreg_q <= hold_wreg_d;
      hold_rn_q   <= hold_rn_d;
      hold_wz_q   <= hold_wz_d;
      hold_z_q    <= hold_z_d;
      wreg_q      <= wreg_d;
      rn_q        <= rn_d;
      wdi_q       <= wdi_d;
      z_q         <= z_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
    end
  end

endmodule
